// File: rtl/clause_checker_pkg.sv
// Shared sizing constants for the clause checker and its evaluators.
// The accumulator width guarantees the clause sum never wraps.
package clause_checker_pkg;

    localparam int NUMBER_OF_INTEGER_VARIABLES   = 2;
    localparam int BIT_WIDTH_OF_INTEGER_VARIABLE = 8;

    localparam int PRODUCT_WIDTH = 2 * BIT_WIDTH_OF_INTEGER_VARIABLE;
    localparam int ACC_WIDTH     = PRODUCT_WIDTH + $clog2(NUMBER_OF_INTEGER_VARIABLES + 1) + 1;

    localparam int COEF_BUS_WIDTH   = (NUMBER_OF_INTEGER_VARIABLES + 1) * BIT_WIDTH_OF_INTEGER_VARIABLE;
    localparam int ASSIGN_BUS_WIDTH = NUMBER_OF_INTEGER_VARIABLES * BIT_WIDTH_OF_INTEGER_VARIABLE;

    localparam int NUM_CLAUSES = 2;

endpackage

// File: rtl/clause_checker_clause_evaluator.sv
// Combinational evaluation of one linear clause sum(ak*yk) <= b.
// All fields are signed; products and the running sum are kept at full precision.
module clause_evaluator
    import clause_checker_pkg::*;
(
    input  logic [COEF_BUS_WIDTH-1:0]   in_coefficients,
    input  logic [ASSIGN_BUS_WIDTH-1:0] in_assignment,
    output logic                        out_satisfied
);

    localparam int N = NUMBER_OF_INTEGER_VARIABLES;
    localparam int W = BIT_WIDTH_OF_INTEGER_VARIABLE;

    logic signed [W-1:0]             bound;
    logic signed [ACC_WIDTH-1:0]     bound_ext;
    logic signed [PRODUCT_WIDTH-1:0] product   [N];
    logic signed [ACC_WIDTH-1:0]     prod_ext  [N];
    logic signed [ACC_WIDTH-1:0]     part_sum  [N+1];

    assign bound     = in_coefficients[W-1:0];
    assign bound_ext = {{(ACC_WIDTH-W){bound[W-1]}}, bound};
    assign part_sum[0] = '0;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_term
            logic signed [W-1:0] coef;
            logic signed [W-1:0] var_val;

            assign coef     = in_coefficients[(gi+2)*W-1 : (gi+1)*W];
            assign var_val  = in_assignment[(gi+1)*W-1 : gi*W];
            assign product[gi]  = coef * var_val;
            // Explicit sign extension keeps the sum from ever wrapping.
            assign prod_ext[gi] = {{(ACC_WIDTH-PRODUCT_WIDTH){product[gi][PRODUCT_WIDTH-1]}}, product[gi]};
            assign part_sum[gi+1] = part_sum[gi] + prod_ext[gi];
        end
    endgenerate

    assign out_satisfied = (part_sum[N] <= bound_ext);

endmodule

// File: rtl/clause_checker.sv
// Two parallel clause evaluators feeding a 2-bit enable-gated flag register.
// out_flag[0] reports clause 1, out_flag[1] reports clause 2.
module clause_checker
    import clause_checker_pkg::*;
(
    input  logic                        in_clk,
    input  logic                        in_reset_n,
    input  logic                        in_enable,
    input  logic [COEF_BUS_WIDTH-1:0]   in_coefficients_clause1,
    input  logic [COEF_BUS_WIDTH-1:0]   in_coefficients_clause2,
    input  logic [ASSIGN_BUS_WIDTH-1:0] in_current_assignment,
    output logic [NUM_CLAUSES-1:0]      out_flag
);

    logic [NUM_CLAUSES-1:0]    sat;
    logic [COEF_BUS_WIDTH-1:0] coef_bus [NUM_CLAUSES];
    logic [NUM_CLAUSES-1:0]    flag_d;
    logic [NUM_CLAUSES-1:0]    flag_q;

    assign coef_bus[0] = in_coefficients_clause1;
    assign coef_bus[1] = in_coefficients_clause2;

    generate
        for (genvar gi = 0; gi < NUM_CLAUSES; gi++) begin : g_clause
            clause_evaluator u_eval (
                .in_coefficients (coef_bus[gi]),
                .in_assignment   (in_current_assignment),
                .out_satisfied   (sat[gi])
            );
        end
    endgenerate

    always_comb begin
        flag_d = flag_q;
        if (in_enable) begin
            flag_d = sat;
        end
    end

    always_ff @(posedge in_clk or negedge in_reset_n) begin
        if (!in_reset_n) begin
            flag_q <= '0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign out_flag = flag_q;

endmodule

// File: tb/tb_clause_checker.sv
// Scoreboard bench for clause_checker: expected flags are queued when stimulus
// is driven and compared one cycle later when the register updates.
module tb_clause_checker;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [23:0] c1;
    logic [23:0] c2;
    logic [15:0] asg;
    logic [1:0]  flag;

    int checks   = 0;
    int failures = 0;

    logic [1:0] exp_q;
    logic [1:0] sb_q [$];

    clause_checker dut (
        .in_clk                  (clk),
        .in_reset_n              (rst_n),
        .in_enable               (enable),
        .in_coefficients_clause1 (c1),
        .in_coefficients_clause2 (c2),
        .in_current_assignment   (asg),
        .out_flag                (flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [1:0] got, input logic [1:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%b want=%b", tag, got, want);
        end
    endtask

    function automatic logic clause_ok(input logic [23:0] c, input logic [15:0] y);
        int b, a1, a2, y1, y2;
        logic [7:0] f;
        f = c[7:0];   b  = int'($signed(f));
        f = c[15:8];  a1 = int'($signed(f));
        f = c[23:16]; a2 = int'($signed(f));
        f = y[7:0];   y1 = int'($signed(f));
        f = y[15:8];  y2 = int'($signed(f));
        return (a1 * y1 + a2 * y2) <= b;
    endfunction

    // Drive on the falling edge, score after the next rising edge.
    task automatic apply(input string tag, input logic en,
                         input logic [23:0] k1, input logic [23:0] k2, input logic [15:0] y);
        logic [1:0] want;
        @(negedge clk);
        enable = en;
        c1 = k1;
        c2 = k2;
        asg = y;
        if (en) exp_q = {clause_ok(k2, y), clause_ok(k1, y)};
        sb_q.push_back(exp_q);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s scoreboard_empty got=%b want=none", tag, flag);
        end else begin
            want = sb_q.pop_front();
            $display("txn %s en=%b c1=%h c2=%h asg=%h flag=%b exp=%b", tag, en, k1, k2, y, flag, want);
            check_val(tag, flag, want);
        end
    endtask

    task automatic pulse_reset(input string tag);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        sb_q.delete();
        exp_q = 2'b00;
        #1;
        check_val(tag, flag, 2'b00);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b1;
        enable = 1'b0;
        c1  = 24'($urandom);
        c2  = 24'($urandom);
        asg = 16'($urandom);
        exp_q = 2'b00;

        // 1: asynchronous reset before any clock edge, then release with enable low
        #2;
        rst_n = 1'b0;
        #1;
        check_val("reset_async", flag, 2'b00);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        apply("reset_release_hold", 1'b0, 24'($urandom), 24'($urandom), 16'($urandom));
        apply("reset_release_hold2", 1'b0, 24'($urandom), 24'($urandom), 16'($urandom));

        // 2..5: directed scenarios
        apply("both_violated", 1'b1, 24'h020101, 24'h010101, 16'h0101);
        apply("both_satisfied", 1'b1, 24'h020101, 24'h010101, 16'hFFFF);
        apply("equality_neg_bound", 1'b1, 24'h0201FD, 24'h0101FD, 16'hFFFF);
        apply("no_overflow", 1'b1, 24'h7F7F80, 24'h808000, 16'h7F7F);
        apply("extreme_neg", 1'b1, 24'h808080, 24'h80807F, 16'h8080);

        // 6: hold with enable low, then reset between edges
        apply("reach_11", 1'b1, 24'h020101, 24'h010101, 16'hFFFF);
        apply("hold_11", 1'b0, 24'h020101, 24'h010101, 16'h0101);
        apply("hold_11_again", 1'b0, 24'h7F7F80, 24'h808000, 16'h7F7F);
        pulse_reset("reset_mid_op");
        apply("after_reset_hold", 1'b0, 24'h020101, 24'h010101, 16'hFFFF);

        // Random coverage against the integer model
        for (int i = 0; i < 24; i++) begin
            apply($sformatf("rand_%0d", i), 1'($urandom_range(0, 3) != 0),
                  24'($urandom), 24'($urandom), 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout got=running want=finished");
        $fatal(1, "timeout");
    end

endmodule
